// File: rtl/bridge_reg_cdc_bank.sv
// Bank of bridge-written control registers carried from clk_74a into a pixel clock
// through one shared toggle req/ack handshake, with optional frame-aligned commit.
module bridge_reg_cdc_bank #(
  parameter int unsigned       NUM_REGS        = 4,
  parameter int unsigned       WIDTH           = 10,
  parameter logic [31:0]       BASE_ADDR       = 32'h0020_0000,
  parameter bit                COMMIT_ON_FRAME = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
  input  logic                      clk_74a,
  input  logic                      reset_n,
  input  logic [31:0]               bridge_addr,
  input  logic                      bridge_wr,
  input  logic [31:0]               bridge_wr_data,
  output logic                      busy,
  output logic [NUM_REGS-1:0]       pending,
  input  logic                      clk_dst,
  input  logic                      dst_frame_start,
  output logic [NUM_REGS*WIDTH-1:0] dst_regs,
  output logic                      dst_update
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, REQ, WAIT_ACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow [NUM_REGS];
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last_sent;
  logic [WIDTH-1:0] xfer_data;
  logic [IDX_W-1:0] xfer_idx;
  logic             req;
  logic [2:0]       ack_sync_ff;

  logic             ack;
  logic [1:0]       dst_rst_ff;
  logic             dst_rst_n;
  logic [2:0]       req_sync_ff;
  logic [WIDTH-1:0] staging [NUM_REGS];
  logic [WIDTH-1:0] dst_q   [NUM_REGS];
  logic             dirty;

  logic             wr_hit_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [IDX_W-1:0] rr_sel_c;
  logic             capture_c;
  logic             commit_c;
  logic             unused_wr_data;

  // Decode: word-aligned hits inside the 64-byte window, indices beyond the bank dropped
  assign wr_hit_c = bridge_wr
                 && (bridge_addr[31:6] == BASE_ADDR[31:6])
                 && (bridge_addr[1:0] == 2'b00)
                 && (32'(bridge_addr[5:2]) < NUM_REGS);
  assign wr_idx_c = IDX_W'(bridge_addr[5:2]);
  assign unused_wr_data = ^bridge_wr_data;

  // Round-robin pick, searching upward from the register after the last one sent
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    rr_sel_c = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      cand = IDX_W'((32'(last_sent) + 32'd1 + k) % NUM_REGS);
      if (!found && pending[cand]) begin
        rr_sel_c = cand;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_ff <= '0;
    end else begin
      ack_sync_ff <= {ack_sync_ff[1:0], ack};
    end
  end

  // Source FSM; a write landing on the index being loaded keeps it pending
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shadow    <= '{default: RESET_VALUE};
      pending   <= '0;
      sel       <= '0;
      last_sent <= LAST_IDX;
      xfer_data <= RESET_VALUE;
      xfer_idx  <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (|pending) || (state != IDLE);
      if (state == LOAD) pending[sel] <= 1'b0;
      if (wr_hit_c) begin
        shadow[wr_idx_c]  <= bridge_wr_data[WIDTH-1:0];
        pending[wr_idx_c] <= 1'b1;
      end
      case (state)
        IDLE: if (|pending) begin
          sel       <= rr_sel_c;
          last_sent <= rr_sel_c;
          state     <= LOAD;
        end
        LOAD: begin
          xfer_data <= shadow[sel];
          xfer_idx  <= sel;
          state     <= REQ;
        end
        REQ: begin
          req   <= ~req;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (ack_sync_ff[2] == req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_dst or negedge reset_n) begin
    if (!reset_n) begin
      dst_rst_ff <= '0;
    end else begin
      dst_rst_ff <= {dst_rst_ff[0], 1'b1};
    end
  end
  assign dst_rst_n = dst_rst_ff[1];

  // ack follows req, so any difference after synchronization is a new transfer
  assign capture_c = req_sync_ff[2] != ack;
  assign commit_c  = dst_frame_start && (dirty || capture_c);

  always_ff @(posedge clk_dst or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      req_sync_ff <= '0;
      ack         <= 1'b0;
      staging     <= '{default: RESET_VALUE};
      dst_q       <= '{default: RESET_VALUE};
      dirty       <= 1'b0;
      dst_update  <= 1'b0;
    end else begin
      req_sync_ff <= {req_sync_ff[1:0], req};
      dst_update  <= 1'b0;
      if (capture_c) begin
        staging[xfer_idx] <= xfer_data;
        ack               <= ~ack;
      end
      if (!COMMIT_ON_FRAME) begin
        if (capture_c) begin
          dst_q[xfer_idx] <= xfer_data;
          dst_update      <= 1'b1;
        end
      end else if (commit_c) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          dst_q[i] <= (capture_c && (xfer_idx == IDX_W'(i))) ? xfer_data : staging[i];
        end
        dirty      <= 1'b0;
        dst_update <= 1'b1;
      end else if (capture_c) begin
        dirty <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign dst_regs[g*WIDTH +: WIDTH] = dst_q[g];
  end

endmodule

// File: tb/tb_bridge_reg_cdc_bank.sv
// Scoreboard bench: one immediate-commit and one frame-commit instance; expected
// dst_regs snapshots are queued at stimulus time and checked on every dst_update.
`timescale 1ns/1ps
module tb_bridge_reg_cdc_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 10;
  localparam int unsigned DW = N * W;
  localparam logic [31:0] BASE = 32'h0020_0000;

  logic          clk_74a = 1'b0;
  logic          clk_dst = 1'b0;
  logic          reset_n;
  logic [31:0]   bridge_addr;
  logic [31:0]   bridge_wr_data;
  logic          bridge_wr0, bridge_wr1;
  logic          dst_frame_start;
  logic          busy0, busy1;
  logic [N-1:0]  pending0, pending1;
  logic [DW-1:0] dst_regs0, dst_regs1;
  logic          dst_update0, dst_update1;

  int vectors = 0;
  int miscompares = 0;
  int upd_cnt0 = 0;
  int upd_cnt1 = 0;
  int coal_cnt = 0;
  bit loose0 = 1'b0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] mdl0 = '0;
  logic [DW-1:0] mdl1 = '0;

  always #6.734 clk_74a = ~clk_74a;
  always #40.690 clk_dst = ~clk_dst;

  bridge_reg_cdc_bank #(.NUM_REGS(N), .WIDTH(W), .BASE_ADDR(BASE), .COMMIT_ON_FRAME(1'b0)) dut0 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr0),
    .bridge_wr_data(bridge_wr_data), .busy(busy0), .pending(pending0), .clk_dst(clk_dst),
    .dst_frame_start(dst_frame_start), .dst_regs(dst_regs0), .dst_update(dst_update0));

  bridge_reg_cdc_bank #(.NUM_REGS(N), .WIDTH(W), .BASE_ADDR(BASE), .COMMIT_ON_FRAME(1'b1)) dut1 (
    .clk_74a(clk_74a), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr1),
    .bridge_wr_data(bridge_wr_data), .busy(busy1), .pending(pending1), .clk_dst(clk_dst),
    .dst_frame_start(dst_frame_start), .dst_regs(dst_regs1), .dst_update(dst_update1));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] setreg(input logic [DW-1:0] v, input int i, input logic [W-1:0] x);
    logic [DW-1:0] r;
    r = v;
    r[i*W +: W] = x;
    return r;
  endfunction

  // Monitor for the immediate-commit instance
  always @(negedge clk_dst) begin : mon0
    logic [DW-1:0] e;
    if (dst_update0) begin
      upd_cnt0++;
      vectors++;
      if (loose0) begin
        coal_cnt++;
        if (dst_regs0[W-1:0] < 10'd1 || dst_regs0[W-1:0] > 10'd5) begin
          miscompares++;
          $display("FAIL coalesce_intermediate: got %h expected value in 1..5", dst_regs0[W-1:0]);
        end
      end else if (q0.size() == 0) begin
        miscompares++;
        $display("FAIL upd0_unexpected: got dst_regs %h with no update expected", dst_regs0);
      end else begin
        e = q0.pop_front();
        if (dst_regs0 !== e) begin
          miscompares++;
          $display("FAIL upd0_value: got %h expected %h", dst_regs0, e);
        end
      end
    end
  end

  // Monitor for the frame-commit instance
  always @(negedge clk_dst) begin : mon1
    logic [DW-1:0] e;
    if (dst_update1) begin
      upd_cnt1++;
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL upd1_unexpected: got dst_regs %h with no update expected", dst_regs1);
      end else begin
        e = q1.pop_front();
        if (dst_regs1 !== e) begin
          miscompares++;
          $display("FAIL upd1_value: got %h expected %h", dst_regs1, e);
        end
      end
    end
  end

  task automatic bwrite(input bit which, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_74a);
    bridge_addr    = a;
    bridge_wr_data = d;
    bridge_wr0     = !which;
    bridge_wr1     = which;
  endtask

  task automatic bidle();
    @(negedge clk_74a);
    bridge_wr0 = 1'b0;
    bridge_wr1 = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input int maxc, input string name);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      @(negedge clk_74a);
      n++;
      if (which ? (!busy1 && pending1 == '0) : (!busy0 && pending0 == '0)) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, maxc);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_dst);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    bit bad;
    bit hit;
    logic [W-1:0] rr_vals [N];
    rr_vals = '{10'h011, 10'h022, 10'h033, 10'h044};

    reset_n = 1'b0;
    bridge_addr = '0;
    bridge_wr_data = '0;
    bridge_wr0 = 1'b0;
    bridge_wr1 = 1'b0;
    dst_frame_start = 1'b0;
    #200;
    check("reset_regs0", dst_regs0, '0);
    check("reset_regs1", dst_regs1, '0);
    check("reset_busy0", DW'(busy0), '0);
    check("reset_pending0", DW'(pending0), '0);
    check("reset_update0", DW'(dst_update0), '0);
    @(negedge clk_74a) reset_n = 1'b1;
    settle(4);

    // Single write, upper bits truncated
    mdl0 = setreg(mdl0, 1, 10'h1A5);
    q0.push_back(mdl0);
    u = upd_cnt0;
    bwrite(1'b0, BASE + 32'h4, 32'hFFFF_F1A5);
    bidle();
    wait_idle(1'b0, 80, "single");
    settle(3);
    check("single_regs", dst_regs0, mdl0);
    check("single_updates", DW'(upd_cnt0 - u), DW'(1));
    check("single_busy", DW'(busy0), '0);

    // Coalescing back-to-back writes to one register
    loose0 = 1'b1;
    coal_cnt = 0;
    for (int v = 1; v <= 5; v++) bwrite(1'b0, BASE, 32'(v));
    bidle();
    wait_idle(1'b0, 400, "coalesce");
    settle(3);
    loose0 = 1'b0;
    mdl0 = setreg(mdl0, 0, 10'd5);
    check("coalesce_final", dst_regs0, mdl0);
    check("coalesce_xfers_le2", DW'(coal_cnt >= 1 && coal_cnt <= 2), DW'(1));

    // Decode rejection: out-of-bank index, misaligned, outside window
    bwrite(1'b0, BASE + 32'h10, 32'h3FF);
    bwrite(1'b0, BASE + 32'h02, 32'h3FF);
    bwrite(1'b0, BASE + 32'h40, 32'h3FF);
    bidle();
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk_74a);
      if (busy0 || pending0 != '0) bad = 1'b1;
    end
    check("reject_activity", DW'(bad), '0);
    check("reject_pending", DW'(pending0), '0);
    settle(3);
    check("reject_regs", dst_regs0, mdl0);

    // Round-robin: 0,1,2,3 then idx0 rewritten during idx1 transfer goes last
    for (int i = 0; i < N; i++) begin
      mdl0 = setreg(mdl0, i, rr_vals[i]);
      q0.push_back(mdl0);
    end
    mdl0 = setreg(mdl0, 0, 10'h0AB);
    q0.push_back(mdl0);
    for (int i = 0; i < N; i++) bwrite(1'b0, BASE + 32'(4 * i), 32'(rr_vals[i]));
    bidle();
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge clk_74a);
      if (pending0 == 4'b1100) hit = 1'b1;
    end
    check("rr_idx1_in_flight", DW'(hit), DW'(1));
    bwrite(1'b0, BASE, 32'h0AB);
    bidle();
    wait_idle(1'b0, 800, "round_robin");
    settle(3);
    check("rr_final", dst_regs0, mdl0);
    check("rr_queue_drained", DW'(q0.size()), '0);

    // Frame commit: nothing visible until dst_frame_start, then both at once
    u = upd_cnt1;
    check("frame_pre", dst_regs1, mdl1);
    bwrite(1'b1, BASE, 32'd7);
    bwrite(1'b1, BASE + 32'h8, 32'd9);
    bidle();
    wait_idle(1'b1, 400, "frame_xfer");
    settle(3);
    check("frame_hold_regs", dst_regs1, mdl1);
    check("frame_hold_updates", DW'(upd_cnt1 - u), '0);
    mdl1 = setreg(setreg(mdl1, 0, 10'd7), 2, 10'd9);
    q1.push_back(mdl1);
    @(negedge clk_dst) dst_frame_start = 1'b1;
    @(negedge clk_dst) dst_frame_start = 1'b0;
    settle(3);
    check("frame_regs", dst_regs1, mdl1);
    check("frame_updates", DW'(upd_cnt1 - u), DW'(1));
    @(negedge clk_dst) dst_frame_start = 1'b1;
    @(negedge clk_dst) dst_frame_start = 1'b0;
    settle(3);
    check("frame_second_updates", DW'(upd_cnt1 - u), DW'(1));
    check("frame_second_regs", dst_regs1, mdl1);

    // Reset while the transfer waits for its ack
    bwrite(1'b0, BASE + 32'hC, 32'h2AA);
    bidle();
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk_74a);
      if (pending0 == '0) hit = 1'b1;
    end
    check("rst_loaded", DW'(hit), DW'(1));
    repeat (3) @(negedge clk_74a);
    reset_n = 1'b0;
    #150;
    mdl0 = '0;
    mdl1 = '0;
    check("rst_regs0", dst_regs0, mdl0);
    check("rst_regs1", dst_regs1, mdl1);
    check("rst_busy0", DW'(busy0), '0);
    check("rst_pending0", DW'(pending0), '0);
    @(negedge clk_74a) reset_n = 1'b1;
    settle(4);
    mdl0 = setreg(mdl0, 3, 10'h155);
    q0.push_back(mdl0);
    bwrite(1'b0, BASE + 32'hC, 32'h155);
    bidle();
    wait_idle(1'b0, 80, "post_reset");
    settle(3);
    check("post_reset_regs", dst_regs0, mdl0);
    check("q0_drained", DW'(q0.size()), '0);
    check("q1_drained", DW'(q1.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
